regbank_wb_arbiter: RTL

- Shares the single register-bank write port (C/Cdata/W) between two writeback sources: the ALU result path and the memory-load path.
- Accepts requests with valid/ready handshakes and arbitrates with memory priority plus starvation protection.
- Registers the winning write and drives the bank's C/Cdata/W with one cycle of latency.
- Sits between execute/memory stages and the register bank.

---
 rtl/regbank_pkg.sv | 28 ++
 rtl/rf_starve_counter.sv | 33 +++
 rtl/regbank_wb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank writeback arbiter.
package regbank_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef enum logic {
    MEM_PRI   = 1'b0,
    ALU_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Writes to the zero register are swallowed when discarding is enabled.
  function automatic logic wb_discard(input logic en, input logic [REG_ADDR_W-1:0] addr);
    return en && (addr == XZR_ADDR);
  endfunction

endpackage

// File: rtl/rf_starve_counter.sv
// Saturating loss counter; lim_o flags that the count reaches LIMIT at the next edge.
module rf_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic lim_o
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != LIM))
      cnt_d = CW'(cnt_q + 1'b1);
  end

  // Looking at the next value lets the arbiter switch on the same edge the limit is hit.
  assign lim_o = (cnt_d == LIM);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Two-source writeback arbiter for the register bank: memory priority with ALU
// starvation protection, registered write port. Optional forwarding: WB_BYPASS_EN.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter bit DISCARD_XZR  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [REG_DATA_W-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [REG_DATA_W-1:0] mem_data,
  output logic [REG_ADDR_W-1:0] C,
  output logic [REG_DATA_W-1:0] Cdata,
  output logic                  W,
  output logic                  alu_starved
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] A,
  input  logic [REG_ADDR_W-1:0] B,
  output logic                  Afwd_valid,
  output logic [REG_DATA_W-1:0] Afwd_data,
  output logic                  Bfwd_valid,
  output logic [REG_DATA_W-1:0] Bfwd_data
`endif
);

  localparam logic [0:0] ST_MEM_PRI   = MEM_PRI;
  localparam logic [0:0] ST_ALU_FORCE = ALU_FORCE;

  logic [0:0]            st_q, st_d;
  logic                  force_alu;
  logic                  alu_hs, mem_hs;
  logic                  starve_inc, starve_clr, starve_lim;
  wb_src_e               win_src;
  wb_req_t               win_req;
  logic                  W_q, W_d;
  logic [REG_ADDR_W-1:0] C_q, C_d;
  logic [REG_DATA_W-1:0] Cdata_q, Cdata_d;

  assign force_alu = (st_q == ST_ALU_FORCE);

  // Readies are gated by reset so nothing is accepted on a reset edge.
  assign alu_ready = RST_N && alu_valid && (force_alu || !mem_valid);
  assign mem_ready = RST_N && mem_valid && !(force_alu && alu_valid);
  assign alu_hs    = alu_valid && alu_ready;
  assign mem_hs    = mem_valid && mem_ready;

  always_comb begin
    win_src      = alu_hs ? SRC_ALU : SRC_MEM;
    win_req.addr = (win_src == SRC_ALU) ? alu_addr : mem_addr;
    win_req.data = (win_src == SRC_ALU) ? alu_data : mem_data;
  end

  // ALU_FORCE lasts a single cycle whether or not the ALU actually wins.
  assign starve_inc = !force_alu && mem_hs && alu_valid;
  assign starve_clr = alu_hs || force_alu;

  rf_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .inc_i  (starve_inc),
    .clr_i  (starve_clr),
    .lim_o  (starve_lim)
  );

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_MEM_PRI:   if (starve_lim) st_d = ST_ALU_FORCE;
      ST_ALU_FORCE: st_d = ST_MEM_PRI;
      default:      st_d = ST_MEM_PRI;
    endcase
  end

  always_comb begin
    W_d     = 1'b0;
    C_d     = C_q;
    Cdata_d = Cdata_q;
    if (alu_hs || mem_hs) begin
      C_d     = win_req.addr;
      Cdata_d = win_req.data;
      W_d     = !wb_discard(DISCARD_XZR, win_req.addr);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q    <= ST_MEM_PRI;
      W_q     <= 1'b0;
      C_q     <= '0;
      Cdata_q <= '0;
    end else begin
      st_q    <= st_d;
      W_q     <= W_d;
      C_q     <= C_d;
      Cdata_q <= Cdata_d;
    end
  end

  assign W           = W_q;
  assign C           = C_q;
  assign Cdata       = Cdata_q;
  assign alu_starved = force_alu;

`ifdef WB_BYPASS_EN
  assign Afwd_valid = W_q && (C_q == A);
  assign Afwd_data  = Cdata_q;
  assign Bfwd_valid = W_q && (C_q == B);
  assign Bfwd_data  = Cdata_q;
`endif

endmodule
